jelly_rtos_eventflag_array: RTL and testbench

- Parametrised hardware event-flag unit for the RTOS core: FLG_NUM independent flag patterns of FLGPTN_WIDTH bits, and a waiter table of TSK_NUM entries.
- Adds per-flag TA_CLR auto-clear, a non-blocking poll (POL_FLG), pattern read-back (REF_FLG), wait cancel (CAN_WAI) and a ready-gated task wake-up stream.
- Sits on the RTOS Wishbone slave bus; the wake-up stream drives the scheduler.

---
 rtl/jelly_rtos_eventflag_array_pkg.sv | 30 +++
 rtl/jelly_rtos_eventflag_array_if.sv | 19 +
 rtl/jelly_rtos_eventflag_array_flg_match.sv | 21 ++
 rtl/jelly_rtos_eventflag_array.sv | 231 +++++++++++++++++++++++
 tb/tb_jelly_rtos_eventflag_array.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jelly_rtos_eventflag_array_pkg.sv
// Shared definitions for the RTOS event-flag block.
// Contents: bus decode geometry, opcode constants, wait-mode and
// release-FSM state enumerations.
package jelly_rtos_pkg;

  localparam int DECODE_OPCODE_POS = 0;
  localparam int DECODE_ID_POS     = 8;
  localparam int OPCODE_WIDTH      = 8;
  localparam int ID_WIDTH          = 8;

  localparam logic [OPCODE_WIDTH-1:0] OPC_SET_FLG     = 8'h31;
  localparam logic [OPCODE_WIDTH-1:0] OPC_CLR_FLG     = 8'h32;
  localparam logic [OPCODE_WIDTH-1:0] OPC_WAI_FLG_AND = 8'h33;
  localparam logic [OPCODE_WIDTH-1:0] OPC_WAI_FLG_OR  = 8'h34;
  localparam logic [OPCODE_WIDTH-1:0] OPC_POL_FLG     = 8'h35;
  localparam logic [OPCODE_WIDTH-1:0] OPC_REF_FLG     = 8'h36;
  localparam logic [OPCODE_WIDTH-1:0] OPC_CAN_WAI     = 8'h37;
  localparam logic [OPCODE_WIDTH-1:0] OPC_CLR_ERR     = 8'h3F;

  typedef enum logic {
    AND = 1'b0,
    OR  = 1'b1
  } wai_mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } rel_state_t;

endpackage

// File: rtl/jelly_rtos_eventflag_array_if.sv
// Wishbone slave bundle for the event-flag block.
// Signals: adr (s_wb_adr_i, [7:0] opcode, [15:8] ID), wdat (s_wb_dat_i),
// rdat (s_wb_dat_o), we (s_wb_we_i), sel (s_wb_sel_i, ignored),
// stb (s_wb_stb_i), ack (s_wb_ack_o).
interface jelly_rtos_eventflag_array_if #(
  parameter int WB_ADR_WIDTH = 16,
  parameter int WB_DAT_WIDTH = 32
);
  logic [WB_ADR_WIDTH-1:0]   adr;
  logic [WB_DAT_WIDTH-1:0]   wdat;
  logic [WB_DAT_WIDTH-1:0]   rdat;
  logic                      we;
  logic [WB_DAT_WIDTH/8-1:0] sel;
  logic                      stb;
  logic                      ack;

  modport master (output adr, wdat, we, sel, stb, input rdat, ack);
  modport slave  (input adr, wdat, we, sel, stb, output rdat, ack);
endinterface

// File: rtl/jelly_rtos_eventflag_array_flg_match.sv
// Combinational wait-condition predicate for one waiter.
// Ports: ptn (current flag pattern), waiptn (wait pattern),
// mode (AND: all bits present, OR: any bit present), hit (satisfied).
module jelly_rtos_flg_match
  import jelly_rtos_pkg::*;
#(
  parameter int FLGPTN_WIDTH = 32
)(
  input  logic [FLGPTN_WIDTH-1:0] ptn,
  input  logic [FLGPTN_WIDTH-1:0] waiptn,
  input  wai_mode_t               mode,
  output logic                    hit
);
  logic [FLGPTN_WIDTH-1:0] masked;

  always_comb begin
    masked = ptn & waiptn;
    if (mode == AND) hit = (masked == waiptn);
    else             hit = (masked != '0);
  end
endmodule

// File: rtl/jelly_rtos_eventflag_array.sv
// RTOS event-flag array: FLG_NUM flag patterns, a TSK_NUM-entry waiter
// table and a ready/valid wake-up stream for the scheduler.
// Ports: clk, reset_n (async, active low), s_wb (Wishbone slave bundle),
// cur_tskid (task issuing WAI), wup_tskid/wup_valid/wup_ready (release
// stream), err_busy (sticky: WAI by a task that is already waiting).
module jelly_rtos_eventflag_array
  import jelly_rtos_pkg::*;
#(
  parameter int                      FLG_NUM      = 4,
  parameter int                      FLGPTN_WIDTH = 32,
  parameter int                      TSK_NUM      = 8,
  parameter int                      FLGID_WIDTH  = (FLG_NUM > 1) ? $clog2(FLG_NUM) : 1,
  parameter int                      TSKID_WIDTH  = (TSK_NUM > 1) ? $clog2(TSK_NUM) : 1,
  parameter logic [FLG_NUM-1:0]      CLR_MASK     = {FLG_NUM{1'b0}},
  parameter logic [FLGPTN_WIDTH-1:0] INIT_FLGPTN  = '0,
  parameter int                      WB_ADR_WIDTH = 16,
  parameter int                      WB_DAT_WIDTH = 32
)(
  input  logic                       clk,
  input  logic                       reset_n,
  jelly_rtos_eventflag_array_if.slave s_wb,
  input  logic [TSKID_WIDTH-1:0]     cur_tskid,
  output logic [TSKID_WIDTH-1:0]     wup_tskid,
  output logic                       wup_valid,
  input  logic                       wup_ready,
  output logic                       err_busy
);

  // Flag and waiter state
  logic [FLGPTN_WIDTH-1:0] flgptn      [FLG_NUM];
  logic [FLGPTN_WIDTH-1:0] flg_next    [FLG_NUM];
  logic [TSK_NUM-1:0]      slot_valid;
  logic [FLGID_WIDTH-1:0]  slot_flgid  [TSK_NUM];
  wai_mode_t               slot_mode   [TSK_NUM];
  logic [FLGPTN_WIDTH-1:0] slot_waiptn [TSK_NUM];
  logic [TSK_NUM-1:0]      slot_hit_raw;
  logic [TSK_NUM-1:0]      slot_hit;

  wai_mode_t               pol_mode;
  logic [FLGPTN_WIDTH-1:0] pol_waiptn;
  logic                    pol_hit;

  logic                    ack_r;
  logic [WB_DAT_WIDTH-1:0] rdat_r;
  logic [WB_DAT_WIDTH-1:0] rd_value;

  rel_state_t              state;
  rel_state_t              state_next;
  logic                    rel_fire;
  logic                    rel_clr;
  logic                    any_hit;
  logic [TSKID_WIDTH-1:0]  win;
  logic [FLGID_WIDTH-1:0]  win_flgid;

  // Bus decode
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [ID_WIDTH-1:0]     id;
  logic [FLGID_WIDTH-1:0]  flg_sel;
  logic [TSKID_WIDTH-1:0]  tsk_sel;
  logic [FLGPTN_WIDTH-1:0] wdat_ptn;
  wai_mode_t               wai_mode;
  logic op_en, flg_ok, tsk_ok, cur_ok;
  logic do_set, do_clr, do_wai, wai_ok, wai_busy;
  logic do_pol_wr, do_pol_rd, do_ref, do_can, do_clr_err, cancel_win;
  logic unused_bits;

  assign opcode   = s_wb.adr[DECODE_OPCODE_POS +: OPCODE_WIDTH];
  assign id       = s_wb.adr[DECODE_ID_POS +: ID_WIDTH];
  assign flg_sel  = id[FLGID_WIDTH-1:0];
  assign tsk_sel  = id[TSKID_WIDTH-1:0];
  assign wdat_ptn = s_wb.wdat[FLGPTN_WIDTH-1:0];
  assign wai_mode = (opcode == OPC_WAI_FLG_OR) ? OR : AND;

  // A strobe is taken only while ack is low, so each access commits once.
  assign op_en  = s_wb.stb && !ack_r;
  assign flg_ok = (int'(id) < FLG_NUM);
  assign tsk_ok = (int'(id) < TSK_NUM);
  assign cur_ok = (int'(cur_tskid) < TSK_NUM);

  assign do_set     = op_en &&  s_wb.we && (opcode == OPC_SET_FLG) && flg_ok;
  assign do_clr     = op_en &&  s_wb.we && (opcode == OPC_CLR_FLG) && flg_ok;
  assign do_wai     = op_en &&  s_wb.we && flg_ok && cur_ok && (wdat_ptn != '0) &&
                      ((opcode == OPC_WAI_FLG_AND) || (opcode == OPC_WAI_FLG_OR));
  // A slot still valid here is also the one being released on this edge,
  // so that case naturally reports busy.
  assign wai_busy   = do_wai &&  slot_valid[cur_tskid];
  assign wai_ok     = do_wai && !slot_valid[cur_tskid];
  assign do_pol_wr  = op_en &&  s_wb.we && (opcode == OPC_POL_FLG);
  assign do_pol_rd  = op_en && !s_wb.we && (opcode == OPC_POL_FLG) && flg_ok;
  assign do_ref     = op_en && !s_wb.we && (opcode == OPC_REF_FLG) && flg_ok;
  assign do_can     = op_en &&  s_wb.we && (opcode == OPC_CAN_WAI) && tsk_ok;
  assign do_clr_err = op_en &&  s_wb.we && (opcode == OPC_CLR_ERR);
  assign cancel_win = do_can && (tsk_sel == win);

  assign unused_bits = ^{s_wb.sel, s_wb.wdat, s_wb.adr};

  // Waiter evaluation against registered patterns
  for (genvar i = 0; i < TSK_NUM; i++) begin : g_slot
    jelly_rtos_flg_match #(.FLGPTN_WIDTH(FLGPTN_WIDTH)) u_match (
      .ptn    (flgptn[slot_flgid[i]]),
      .waiptn (slot_waiptn[i]),
      .mode   (slot_mode[i]),
      .hit    (slot_hit_raw[i])
    );
    assign slot_hit[i] = slot_valid[i] && slot_hit_raw[i];
  end

  jelly_rtos_flg_match #(.FLGPTN_WIDTH(FLGPTN_WIDTH)) u_pol_match (
    .ptn    (flgptn[flg_sel]),
    .waiptn (pol_waiptn),
    .mode   (pol_mode),
    .hit    (pol_hit)
  );

  // Lowest satisfied task ID wins.
  always_comb begin
    any_hit = 1'b0;
    win     = '0;
    for (int i = TSK_NUM - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        any_hit = 1'b1;
        win     = TSKID_WIDTH'(i);
      end
    end
  end

  assign win_flgid = slot_flgid[win];

  // Release FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (rel_fire)  state_next = ST_OFFER;
      ST_OFFER: if (wup_ready) state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wup_valid = (state == ST_OFFER);
    // A cancel of the selected slot on the same edge suppresses the release.
    rel_fire  = (state == ST_IDLE) && any_hit && !cancel_win;
    rel_clr   = rel_fire && CLR_MASK[win_flgid];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      wup_tskid <= '0;
    else if (rel_fire) wup_tskid <= win;
  end

  // Flag patterns: TA_CLR clear is applied first, so a same-edge SET
  // leaves exactly the SET data.
  always_comb begin
    for (int f = 0; f < FLG_NUM; f++) begin
      flg_next[f] = flgptn[f];
      if (rel_clr && (win_flgid == FLGID_WIDTH'(f))) flg_next[f] = '0;
      if (do_set  && (flg_sel   == FLGID_WIDTH'(f))) flg_next[f] = flg_next[f] | wdat_ptn;
      if (do_clr  && (flg_sel   == FLGID_WIDTH'(f))) flg_next[f] = flg_next[f] & wdat_ptn;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int f = 0; f < FLG_NUM; f++) flgptn[f] <= INIT_FLGPTN;
    end else begin
      flgptn <= flg_next;
    end
  end

  // Waiter table
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid <= '0;
    end else begin
      for (int i = 0; i < TSK_NUM; i++) begin
        if ((rel_fire && (win == TSKID_WIDTH'(i))) || (do_can && (tsk_sel == TSKID_WIDTH'(i))))
          slot_valid[i] <= 1'b0;
        else if (wai_ok && (cur_tskid == TSKID_WIDTH'(i)))
          slot_valid[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < TSK_NUM; i++) begin
      if (wai_ok && (cur_tskid == TSKID_WIDTH'(i))) begin
        slot_flgid[i]  <= flg_sel;
        slot_mode[i]   <= wai_mode;
        slot_waiptn[i] <= wdat_ptn;
      end
    end
  end

  // Poll condition comes from the last write to the POL_FLG opcode: its
  // data is the poll pattern and its bit 0 selects the mode.
  always_ff @(posedge clk) begin
    if (do_pol_wr) begin
      pol_mode   <= wai_mode_t'(s_wb.wdat[0]);
      pol_waiptn <= wdat_ptn;
    end
  end

  // Bus response
  always_comb begin
    rd_value = '0;
    if (do_ref)         rd_value = WB_DAT_WIDTH'(flgptn[flg_sel]);
    else if (do_pol_rd) rd_value = WB_DAT_WIDTH'(pol_hit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_r    <= 1'b0;
      rdat_r   <= '0;
      err_busy <= 1'b0;
    end else begin
      ack_r  <= op_en;
      rdat_r <= rd_value;
      if (wai_busy)        err_busy <= 1'b1;
      else if (do_clr_err) err_busy <= 1'b0;
    end
  end

  assign s_wb.ack  = ack_r;
  assign s_wb.rdat = rdat_r;

endmodule

// File: tb/tb_jelly_rtos_eventflag_array.sv
// Self-checking bench for jelly_rtos_eventflag_array: directed scenarios
// followed by randomized operations scored against an abstract model of
// flag patterns, waiters and the expected release order.
module tb_jelly_rtos_eventflag_array;
  import jelly_rtos_pkg::*;

  localparam int          FLG_NUM  = 4;
  localparam int          TSK_NUM  = 8;
  localparam logic [3:0]  CLR_MASK = 4'b0010;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] cur_tskid = '0;
  logic [2:0] wup_tskid;
  logic       wup_valid;
  logic       wup_ready = 1'b0;
  logic       err_busy;

  jelly_rtos_eventflag_array_if #(.WB_ADR_WIDTH(16), .WB_DAT_WIDTH(32)) wb ();

  jelly_rtos_eventflag_array #(
    .FLG_NUM      (FLG_NUM),
    .FLGPTN_WIDTH (32),
    .TSK_NUM      (TSK_NUM),
    .CLR_MASK     (CLR_MASK),
    .INIT_FLGPTN  (32'h0),
    .WB_ADR_WIDTH (16),
    .WB_DAT_WIDTH (32)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_wb      (wb),
    .cur_tskid (cur_tskid),
    .wup_tskid (wup_tskid),
    .wup_valid (wup_valid),
    .wup_ready (wup_ready),
    .err_busy  (err_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Abstract model
  logic [31:0] m_ptn   [FLG_NUM];
  bit          m_valid [TSK_NUM];
  int          m_flg   [TSK_NUM];
  bit          m_or    [TSK_NUM];
  logic [31:0] m_pat   [TSK_NUM];
  bit          m_err;

  function automatic bit sat(logic [31:0] p, logic [31:0] w, bit or_mode);
    if (or_mode) return (p & w) != 0;
    return (p & w) == w;
  endfunction

  function automatic int m_next();
    for (int t = 0; t < TSK_NUM; t++)
      if (m_valid[t] && sat(m_ptn[m_flg[t]], m_pat[t], m_or[t])) return t;
    return -1;
  endfunction

  task automatic m_reset();
    for (int f = 0; f < FLG_NUM; f++) m_ptn[f] = '0;
    for (int t = 0; t < TSK_NUM; t++) m_valid[t] = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input bit we, input logic [7:0] opc, input logic [7:0] id,
                         input logic [31:0] d, output logic [31:0] rd);
    @(negedge clk);
    wb.adr  = {id, opc};
    wb.wdat = d;
    wb.we   = we;
    wb.stb  = 1'b1;
    @(posedge clk);
    #1;
    chk("ack", {31'd0, wb.ack}, 32'd1);
    rd = wb.rdat;
    @(negedge clk);
    wb.stb = 1'b0;
    wb.we  = 1'b0;
  endtask

  task automatic op_set(input int f, input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(1'b1, OPC_SET_FLG, 8'(f), d, rd);
    if (f < FLG_NUM) m_ptn[f] = m_ptn[f] | d;
  endtask

  task automatic op_clr(input int f, input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(1'b1, OPC_CLR_FLG, 8'(f), d, rd);
    if (f < FLG_NUM) m_ptn[f] = m_ptn[f] & d;
  endtask

  task automatic op_wai(input int t, input int f, input bit or_mode, input logic [31:0] pat);
    logic [31:0] rd;
    cur_tskid = 3'(t);
    wb_xfer(1'b1, or_mode ? OPC_WAI_FLG_OR : OPC_WAI_FLG_AND, 8'(f), pat, rd);
    if (f < FLG_NUM && pat != 0) begin
      if (m_valid[t]) m_err = 1'b1;
      else begin
        m_valid[t] = 1'b1;
        m_flg[t]   = f;
        m_or[t]    = or_mode;
        m_pat[t]   = pat;
      end
    end
  endtask

  task automatic op_can(input int t);
    logic [31:0] rd;
    wb_xfer(1'b1, OPC_CAN_WAI, 8'(t), 32'h0, rd);
    if (t < TSK_NUM) m_valid[t] = 1'b0;
  endtask

  task automatic op_ref(input int f);
    logic [31:0] rd;
    wb_xfer(1'b0, OPC_REF_FLG, 8'(f), 32'h0, rd);
    chk("ref_flg", rd, (f < FLG_NUM) ? m_ptn[f] : 32'h0);
  endtask

  task automatic op_pol(input int f, input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(1'b1, OPC_POL_FLG, 8'd0, d, rd);
    wb_xfer(1'b0, OPC_POL_FLG, 8'(f), 32'h0, rd);
    chk("pol_flg", rd, (f < FLG_NUM) ? {31'd0, sat(m_ptn[f], d, d[0])} : 32'h0);
  endtask

  task automatic op_clr_err();
    logic [31:0] rd;
    wb_xfer(1'b1, OPC_CLR_ERR, 8'd0, 32'h0, rd);
    m_err = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (wup_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Consume every release the model predicts, in order, then confirm quiet.
  task automatic drain(input bit tied);
    bit got;
    bit seen;
    int exp;
    for (int iter = 0; iter < 16; iter++) begin
      exp = m_next();
      if (exp < 0) break;
      wait_valid(got);
      chk("wup_valid", {31'd0, got}, 32'd1);
      if (got) chk("wup_tskid", {29'd0, wup_tskid}, 32'(exp));
      if (!tied) begin
        @(negedge clk);
        wup_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        wup_ready = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      m_valid[exp] = 1'b0;
      if (CLR_MASK[m_flg[exp]]) m_ptn[m_flg[exp]] = '0;
    end
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      seen = seen | wup_valid;
    end
    chk("no_release", {31'd0, seen}, 32'd0);
  endtask

  initial begin
    bit          got;
    bit          tied;
    logic [31:0] rd;
    int          r;

    wb.adr  = '0;
    wb.wdat = '0;
    wb.we   = 1'b0;
    wb.sel  = '1;
    wb.stb  = 1'b0;
    m_reset();

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",       {31'd0, wb.ack},    32'd0);
    chk("rst_rdat",      wb.rdat,            32'd0);
    chk("rst_wup_valid", {31'd0, wup_valid}, 32'd0);
    chk("rst_wup_tskid", {29'd0, wup_tskid}, 32'd0);
    chk("rst_err_busy",  {31'd0, err_busy},  32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic set / clear / read-back, plus an out-of-range flag ID
    op_ref(0);
    op_set(0, 32'h5);
    op_ref(0);
    op_clr(0, ~32'h1);
    op_ref(0);
    op_set(9, 32'hFF);
    op_ref(9);
    op_ref(0);

    // AND wait, stalled release held stable until ready
    op_clr(0, 32'h0);
    op_wai(2, 0, 1'b0, 32'h5);
    drain(1'b0);
    op_set(0, 32'h1);
    drain(1'b0);
    op_set(0, 32'h4);
    wait_valid(got);
    chk("and_release_valid", {31'd0, got}, 32'd1);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, wup_valid}, 32'd1);
      chk("hold_tskid", {29'd0, wup_tskid}, 32'd2);
    end
    drain(1'b0);
    op_wai(2, 0, 1'b0, 32'h40);
    chk("slot2_free", {31'd0, err_busy}, {31'd0, m_err});
    op_can(2);
    drain(1'b0);

    // TA_CLR flag: one release per SET
    op_clr(1, 32'h0);
    op_wai(1, 1, 1'b1, 32'h1);
    op_wai(3, 1, 1'b1, 32'h1);
    op_set(1, 32'h1);
    drain(1'b0);
    op_ref(1);
    op_set(1, 32'h1);
    drain(1'b0);
    op_ref(1);

    // Busy error, cancel, error clear
    op_wai(4, 0, 1'b1, 32'h8);
    chk("err_after_first_wai", {31'd0, err_busy}, 32'd0);
    op_wai(4, 0, 1'b1, 32'h8);
    chk("err_busy_set", {31'd0, err_busy}, 32'd1);
    op_can(4);
    op_set(0, 32'h8);
    drain(1'b0);
    op_clr_err();
    chk("err_busy_clr", {31'd0, err_busy}, 32'd0);

    // Two AND waiters on a plain flag, ready tied high
    op_clr(3, 32'h0);
    op_wai(0, 3, 1'b0, 32'h3);
    op_wai(5, 3, 1'b0, 32'h3);
    wup_ready = 1'b1;
    op_set(3, 32'h3);
    drain(1'b1);
    wup_ready = 1'b0;
    op_ref(3);

    // Randomized operations
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 6);
      case (r)
        0: op_set($urandom_range(0, 4), 32'($urandom_range(0, 15)));
        1: op_clr($urandom_range(0, 4), $urandom);
        2: begin
          op_wai($urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 15)));
          chk("rand_err_busy", {31'd0, err_busy}, {31'd0, m_err});
        end
        3: op_can($urandom_range(0, 9));
        4: op_ref($urandom_range(0, 4));
        5: op_pol($urandom_range(0, 4), 32'($urandom_range(0, 15)));
        default: begin
          if ($urandom_range(0, 1) == 1) op_clr_err();
          chk("rand_err_state", {31'd0, err_busy}, {31'd0, m_err});
        end
      endcase
      tied = 1'($urandom_range(0, 1));
      wup_ready = tied;
      drain(tied);
      wup_ready = 1'b0;
    end

    // Reset during a pending release and an in-flight ack
    op_clr(2, 32'h0);
    drain(1'b0);
    op_wai(6, 2, 1'b1, 32'h1);
    wb_xfer(1'b1, OPC_SET_FLG, 8'd2, 32'h1, rd);
    wait_valid(got);
    chk("pre_reset_valid", {31'd0, got}, 32'd1);
    @(negedge clk);
    wb.adr = {8'd2, OPC_REF_FLG};
    wb.we  = 1'b0;
    wb.stb = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_reset_ack", {31'd0, wb.ack}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_reset_ack",   {31'd0, wb.ack},    32'd0);
    chk("mid_reset_valid", {31'd0, wup_valid}, 32'd0);
    chk("mid_reset_tskid", {29'd0, wup_tskid}, 32'd0);
    @(negedge clk);
    wb.stb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    op_ref(2);
    drain(1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
